// File: rtl/mem_preload_ctrl.sv
// Host-to-data-memory preload controller: owns the memory port while the core is
// held in reset, then hands the port to the core after a programmable delay.
module mem_preload_ctrl #(
  parameter int DATA_W        = 32,
  parameter int DEPTH_WORDS   = 64,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic              ext_burst,
  input  logic [2:0]        ext_size,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_done,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_err,
  output logic [15:0]       words_loaded,
  output logic              cpu_reset,
  input  logic              core_MemWrite,
  input  logic [2:0]        core_Store,
  input  logic [31:0]       core_DataAdr,
  input  logic [DATA_W-1:0] core_WriteData,
  output logic              mem_MemWrite,
  output logic [2:0]        mem_Store,
  output logic [31:0]       mem_DataAdr,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS * 4);
  localparam int          CNT_W     = $clog2(RELEASE_DELAY + 1);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        store;
    logic [31:0]       adr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_ptr;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [15:0]       r_words;

  logic              w_accept;
  logic [31:0]       w_eff_addr;
  logic [2:0]        w_nbytes;
  logic              w_size_ok;
  logic              w_align_ok;
  logic [32:0]       w_end_addr;
  logic              w_legal;
  mem_req_t          w_host_req, w_core_req, w_mem_req;

  // Access decode; an illegal size still advances the pointer by one byte.
  always_comb begin
    w_accept   = ext_valid && (r_state == S_LOAD);
    w_eff_addr = ext_burst ? r_ptr : ext_addr;
    w_nbytes   = 3'd1;
    w_size_ok  = 1'b1;
    w_align_ok = 1'b1;
    case (ext_size)
      3'b000: w_nbytes = 3'd1;
      3'b001: begin w_nbytes = 3'd2; w_align_ok = ~w_eff_addr[0]; end
      3'b010: begin w_nbytes = 3'd4; w_align_ok = (w_eff_addr[1:0] == 2'b00); end
      default: w_size_ok = 1'b0;
    endcase
    // 33-bit end address so a request near 2^32 cannot wrap into range.
    w_end_addr = {1'b0, w_eff_addr} + 33'(w_nbytes) - 33'd1;
    w_legal    = w_size_ok && w_align_ok && (w_end_addr < MEM_BYTES);
  end

  always_comb begin
    w_host_req.we    = w_accept && ext_we && w_legal;
    w_host_req.store = ext_size;
    w_host_req.adr   = w_eff_addr;
    w_host_req.wdata = ext_wdata;
    w_core_req.we    = core_MemWrite;
    w_core_req.store = core_Store;
    w_core_req.adr   = core_DataAdr;
    w_core_req.wdata = core_WriteData;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    cpu_reset   = 1'b1;
    ext_ready   = 1'b0;
    w_mem_req   = w_host_req;
    case (r_state)
      S_LOAD: begin
        ext_ready = 1'b1;
        if (ext_done) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = CNT_W'(RELEASE_DELAY);
        end
      end
      S_RELEASE: begin
        w_mem_req.we = 1'b0;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        w_mem_req = w_core_req;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_LOAD;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_words  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_accept && !ext_we;
      if (w_accept) begin
        r_ptr <= w_eff_addr + 32'(w_nbytes);
        if (!w_legal) r_err <= 1'b1;
        if (!ext_we) r_rdata <= w_legal ? mem_ReadData : '0;
        if (ext_we && w_legal && (r_words != 16'hFFFF)) r_words <= r_words + 16'd1;
      end
    end
  end

  assign mem_MemWrite  = w_mem_req.we;
  assign mem_Store     = w_mem_req.store;
  assign mem_DataAdr   = w_mem_req.adr;
  assign mem_WriteData = w_mem_req.wdata;
  assign ext_rvalid    = r_rvalid;
  assign ext_rdata     = r_rdata;
  assign ext_err       = r_err;
  assign words_loaded  = r_words;

endmodule

// File: doc/mem_preload_ctrl.md
# mem_preload_ctrl

Sequential host-to-memory preload controller placed between the pipelined RISC-V core, its data memory and an external host port. After reset it holds the core in reset and gives the host exclusive access to data memory through a valid/ready handshake. Supports single and auto-incrementing burst writes, byte/half/word sizes and read-back. On host `ext_done` it waits a programmable delay, then releases the core and routes the memory port to the core.

## Interface
Parameters:
- `DATA_W`, 32: data width; must be 32.
- `DEPTH_WORDS`, 64: data-memory size in 32-bit words; the legal byte range is `0 .. DEPTH_WORDS*4-1`.
- `RELEASE_DELAY`, 4: number of cycles between accepting `ext_done` and deasserting `cpu_reset`; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ext_valid` in 1: host request valid.
- `ext_ready` out 1: request accepted when `ext_valid && ext_ready`.
- `ext_we` in 1: 1 means write, 0 means read.
- `ext_burst` in 1: 1 means use the internal address pointer; 0 means use `ext_addr`.
- `ext_size` in 3: RV funct3 size code. 000 byte, 001 half, 010 word; any other value is illegal.
- `ext_addr` in 32: byte address.
- `ext_wdata` in 32: write data, right-aligned.
- `ext_done` in 1: host finished loading.
- `ext_rvalid` out 1: read data valid.
- `ext_rdata` out 32: read data.
- `ext_err` out 1: sticky error flag.
- `words_loaded` out 16: count of accepted writes, saturating at 0xFFFF.
- `cpu_reset` out 1: reset to the core.
- `core_MemWrite` in 1, `core_Store` in 3, `core_DataAdr` in 32, `core_WriteData` in 32: core memory request.
- `mem_MemWrite` out 1, `mem_Store` out 3, `mem_DataAdr` out 32, `mem_WriteData` out 32: outputs to data memory.
- `mem_ReadData` in 32: combinational read data from memory; also forwarded to the core.

## Operation
The controller is a three-state FSM: LOAD, RELEASE, RUN.

- **LOAD** (entered on reset):
  - `cpu_reset`=1 and `ext_ready`=1.
  - Memory port outputs are driven from the host side.
  - With no accepted request: `mem_MemWrite`=0.
- **Accepted request, effective address**:
  - Effective address is `ext_addr` when `ext_burst`=0, otherwise `ptr`.
  - After an accept, `ptr` ← effective address + size bytes (1, 2 or 4). This applies to both reads and writes.
- **Legality check** (illegal if any holds):
  - `ext_size` is not 000, 001 or 010.
  - Half access at an odd address.
  - Word access at an address not a multiple of 4.
  - Effective address + size − 1 ≥ `DEPTH_WORDS*4`.
- **Illegal request**:
  - No memory write.
  - `ext_err` ← 1.
  - `ptr` still advances.
  - A read returns 0 with `ext_rvalid` still asserted.
- **Legal write**:
  - `mem_MemWrite`=1, `mem_Store`=`ext_size`, `mem_DataAdr`=effective address, `mem_WriteData`=`ext_wdata`, all in the accept cycle.
  - `words_loaded` increments.
- **Legal read**:
  - `mem_DataAdr`=effective address in the accept cycle.
  - `ext_rdata` registers `mem_ReadData`.
- **`ext_done` in LOAD**:
  - Moves to RELEASE.
  - If a request is accepted in the same cycle, that request completes normally first.
- **RELEASE**:
  - `ext_ready`=0, `mem_MemWrite`=0, `cpu_reset`=1.
  - A down-counter is loaded with `RELEASE_DELAY`; at 0 the FSM moves to RUN.
- **RUN**:
  - `cpu_reset`=0 and `ext_ready`=0.
  - `mem_*` outputs equal `core_*` inputs combinationally.
  - `ext_valid` and `ext_done` are ignored.
  - `ext_err` and `words_loaded` hold their values.
- **Reset in any state**: returns to LOAD on the next edge. Memory contents are untouched.

## Timing
- **Reset values**:
  - FSM=LOAD, `ptr`=0, delay counter=0.
  - `cpu_reset`=1, `ext_rvalid`=0, `ext_rdata`=0, `ext_err`=0, `words_loaded`=0.
- **Write latency**: 0. Memory captures the write on the same edge that completes the handshake.
- **Read latency**: 1 cycle. `ext_rvalid` pulses high the cycle after accept, together with `ext_rdata`.
  - Back-to-back reads give back-to-back `rvalid` pulses.
  - A read accepted in the `ext_done` cycle still returns `rvalid` in the first RELEASE cycle.
- **Release timing**: `ext_done` accepted at cycle T → `cpu_reset` falls after T+1+`RELEASE_DELAY`. With the default delay, `cpu_reset`=0 from cycle T+5.
- **`ptr` wrap**: `ptr` wraps at 2^32 with no special handling; the legality check catches the resulting address.
- **`words_loaded`**: saturates at 0xFFFF and does not wrap.

## Test plan
- **Word burst**: reset, then write 0x11111111 to 0x00 (`burst`=0), then 0x22222222 and 0x33333333 with `burst`=1.
  - Expect memory words 0, 1, 2 written, `words_loaded`=3, `ext_err`=0.
- **Byte write**: byte write of 0xAB to 0x05 (size 000), then word read of 0x04.
  - Expect `ext_rdata`=0x0000AB00 (given a zeroed word) one cycle after accept.
- **Illegal requests**: half at 0x03; word at `DEPTH_WORDS*4`; size 011.
  - Expect no `mem_MemWrite` pulse, `ext_err`=1 sticky, `words_loaded` unchanged.
- **Done with write**: `ext_done` with a simultaneous write at cycle T.
  - Expect the write performed, `ext_ready`=0 at T+1, `cpu_reset`=0 at T+5, then `mem_*` tracking `core_*` (e.g. core write 0xDEADBEEF to 0x10 appears on `mem_*` in the same cycle).
- **Reset in RUN**: assert `reset` during RUN.
  - Expect LOAD, `cpu_reset`=1, `ext_ready`=1, `ext_err`=0, `words_loaded`=0 on the next cycle, with earlier memory contents readable.
- **Read in done cycle**: read accepted in the same cycle as `ext_done`.
  - Expect `ext_rvalid`=1 in the first RELEASE cycle with the correct data.
